// File: rtl/aes_128_inv_subbytes_seq_if.sv
// aes_128_inv_subbytes_seq_if: valid/ready handshake bundle for the InvSubBytes block
//   in_valid/in_ready/in_data    : 128-bit state in, producer -> block
//   out_valid/out_ready/out_data : 128-bit result out, block -> consumer
//   busy                         : block is not idle
interface aes_128_inv_subbytes_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/aes_128_inv_subbytes_seq.sv
// aes_128_inv_subbytes_seq: sequential AES InvSubBytes, one 32-bit column per clock
//   clk  : clock, rising edge
//   kill : synchronous active-high reset, aborts any block in flight
//   bus  : slave side of aes_128_inv_subbytes_seq_if (in/out handshakes, busy)
//   SBOX_LAT : inverse S-box ROM read latency, 1 or 2
module aes_128_inv_subbytes_seq #(
   parameter int SBOX_LAT = 1
) (
   input logic                         clk,
   input logic                         kill,
   aes_128_inv_subbytes_seq_if.slave   bus
);
   // FIPS-197 inverse S-box, entry 0 in the most significant byte
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;
   state_t        state;
   logic [1:0]    cnt;
   logic [127:0]  in_reg;
   logic [31:0]   col_in;
   logic [31:0]   col_rom;
   logic [31:0]   pd [SBOX_LAT];
   logic [1:0]    pc [SBOX_LAT];
   logic [SBOX_LAT-1:0] pv;
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return INV_SBOX[{~a, 3'b000} +: 8];
   endfunction
   assign col_in  = in_reg[{cnt, 5'b0} +: 32];
   assign col_rom = {inv_sbox(col_in[31:24]), inv_sbox(col_in[23:16]),
                     inv_sbox(col_in[15:8]), inv_sbox(col_in[7:0])};
   assign bus.in_ready = (state == IDLE) && !kill;
   // ROM read pipeline: data and column tag are never reset, only the valid bits are
   always_ff @(posedge clk) begin
      pd[0] <= col_rom;
      pc[0] <= cnt;
      for (int k = 1; k < SBOX_LAT; k++) begin
         pd[k] <= pd[k-1];
         pc[k] <= pc[k-1];
      end
   end
   always_ff @(posedge clk) begin
      if (kill) begin
         state         <= IDLE;
         cnt           <= 2'd0;
         in_reg        <= '0;
         pv            <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.busy      <= 1'b0;
      end else begin
         pv[0] <= (state == ISSUE);
         for (int k = 1; k < SBOX_LAT; k++) pv[k] <= pv[k-1];
         if (pv[SBOX_LAT-1]) bus.out_data[{pc[SBOX_LAT-1], 5'b0} +: 32] <= pd[SBOX_LAT-1];
         case (state)
            IDLE: if (bus.in_valid) begin
               in_reg   <= bus.in_data;
               cnt      <= 2'd0;
               bus.busy <= 1'b1;
               state    <= ISSUE;
            end
            ISSUE: begin
               cnt   <= cnt + 2'd1;
               state <= (cnt == 2'd3) ? DRAIN : ISSUE;
            end
            // column 3 lands in out_data on the same edge that raises out_valid
            DRAIN: if (pv[SBOX_LAT-1] && pc[SBOX_LAT-1] == 2'd3) begin
               bus.out_valid <= 1'b1;
               state         <= HOLD;
            end
            HOLD: if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
               bus.busy      <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/aes_128_inv_subbytes_seq.md
AES_128_INV_SUBBYTES_SEQ -- requirements
Module: aes_128_inv_subbytes_seq

Interface
REQ-001 The block SHALL have one parameter: SBOX_LAT, default 1, inverse S-box ROM read latency in clocks (legal values 1 or 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port kill, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data holds a state block to transform.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a state; transfer when in_valid && in_ready at a rising edge.
REQ-006 The block SHALL have port in_data, input, 128 bits: AES state; byte i = bits [8i+7:8i].
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_data holds a completed result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer takes the result; transfer when out_valid && out_ready at a rising edge.
REQ-009 The block SHALL have port out_data, output, 128 bits: InvSubBytes result; byte i = InvSbox(input byte i).
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, ISSUE, DRAIN and HOLD.
REQ-012 In IDLE, in_ready SHALL be 1 when kill=0; it SHALL be 0 in every other state.
REQ-013 On acceptance, in IDLE: the block SHALL latch in_data into an internal 128-bit register, clear the column counter to 0, and go to ISSUE.
REQ-014 ISSUE SHALL present one 32-bit column per cycle, column c = bytes 4c..4c+3, c = 0,1,2,3 in order, to four parallel inverse S-box ROM lookups.
REQ-015 The column counter SHALL be 2 bits; after issuing c=3 the FSM SHALL go to DRAIN and the counter SHALL wrap to 0.
REQ-016 Each ROM result SHALL be written into out_data column c exactly SBOX_LAT clocks after that column was issued.
REQ-017 The FSM SHALL leave DRAIN once column 3 is written; it SHALL then go to HOLD and assert out_valid.
REQ-018 Latency SHALL be 4+SBOX_LAT clocks: out_valid is first high 4+SBOX_LAT rising edges after the acceptance edge.
REQ-019 The block SHALL be non-pipelined; it SHALL hold at most one state block in flight.
REQ-020 In HOLD, out_valid SHALL stay 1 and out_data SHALL stay stable until out_ready=1.
REQ-021 On an output transfer the FSM SHALL go to IDLE; out_valid SHALL drop on that edge, and in_ready SHALL be 1 in the next cycle.
REQ-022 There SHALL be no same-cycle bypass from output transfer to a new acceptance.
REQ-023 out_data SHALL keep its last value after a transfer until column 0 of the next block is written.
REQ-024 in_data and in_valid SHALL be ignored outside IDLE; changing them mid-operation SHALL NOT affect the result.
REQ-025 out_ready SHALL be ignored outside HOLD.
REQ-026 The ROM SHALL be the standard FIPS-197 inverse S-box (256x8), held in synchronous-read BRAM; it SHALL NOT be reset.

Reset
REQ-027 While kill=1 at a rising edge, the block SHALL force: FSM=IDLE, column counter=0, out_valid=0, busy=0, out_data=128'h0, internal input register=128'h0.
REQ-028 While kill is 1, in_ready SHALL be 0.
REQ-029 kill asserted in any state, including mid-ISSUE, DRAIN or HOLD, SHALL abort the block in flight; no later out_valid SHALL arise from it.
REQ-030 ROM read data still in flight when kill deasserts SHALL be discarded.
REQ-031 The first acceptance SHALL be possible in the first cycle after kill deasserts.

Verification
REQ-032 Scenario: in_data=128'hf0e0d0c0b0a090807060504030201000, out_ready=1, SBOX_LAT=1 -> out_data=128'h17a0601ffc47963ad0906c7208547c52 with out_valid high exactly 5 edges after acceptance, held for 1 cycle.
REQ-033 Scenario: in_data=all bytes 8'h63 -> out_data=128'h0. Also in_data=128'h0 -> all bytes 8'h52.
REQ-034 Scenario: 16 blocks with byte i of block k = 16k+i (all 256 values) -> each byte matches the FIPS-197 InvSbox model. Repeat with SBOX_LAT=2: latency becomes 6.
REQ-035 Scenario: out_ready held 0 for 10 cycles after out_valid -> out_valid and out_data stable, in_ready=0, busy=1. Then out_ready=1 for 1 cycle -> in_ready=1 on the next cycle.
REQ-036 Scenario: kill pulsed 1 cycle during ISSUE column 2 -> out_valid=0, out_data=0 and in_ready=1 after the pulse; a following block returns the correct result with nominal latency.
REQ-037 Scenario: in_valid held 1 with changing in_data while busy -> only the block accepted in IDLE is transformed; the count of accepted blocks equals the count of output transfers.
